// File: rtl/out_port_pkg.sv
// Shared defaults and output-stage state encoding for the output port controller.
package out_port_pkg;

    localparam int         DefaultDepth  = 4;
    localparam logic [7:0] DefaultStrobe = 8'hFF;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } out_state_e;

endpackage

// File: rtl/out_port_fifo.sv
// Circular FIFO behind the output stage. Depth must be a power of two so the
// pointers wrap naturally; clr outranks push and pop.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = DefaultDepth
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         wr_data,
    output logic [Width-1:0]         head,
    output logic [$clog2(Depth):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        full_d = (count_d == CW'(Depth));
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage itself carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/out_port_ctrl.sv
// Output port controller: decodes ALU strobe writes, feeds a single-word output
// stage directly when the FIFO is empty, otherwise queues behind it.
module out_port_ctrl
    import out_port_pkg::*;
#(
    parameter int               Psize      = 8,
    parameter int               Depth      = DefaultDepth,
    parameter logic [Psize-1:0] StrobeCode = Psize'(DefaultStrobe)
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [Psize-1:0]       RegIn,
    input  logic [Psize-1:0]       ALURes,
    input  logic                   clr,
    input  logic                   out_ready,
    output logic [Psize-1:0]       out_data,
    output logic                   out_valid,
    output logic                   full,
    output logic                   overflow,
    output logic [$clog2(Depth):0] count
);

    localparam int CW = $clog2(Depth) + 1;

    out_state_e       state_q, state_d;
    logic [Psize-1:0] out_data_q, out_data_d;
    logic             overflow_q, overflow_d;

    logic             wr_req, can_load, fifo_empty, bypass, pop, push, drop;
    logic [Psize-1:0] fifo_head;
    logic [CW-1:0]    fifo_count;

    // The stage can take a new word when idle or when its current word leaves.
    always_comb begin
        wr_req     = (ALURes == StrobeCode);
        fifo_empty = (fifo_count == '0);
        can_load   = (state_q == IDLE) || out_ready;
        pop        = can_load && !fifo_empty;
        bypass     = can_load && fifo_empty && wr_req;
        push       = wr_req && !bypass && (fifo_count < CW'(Depth)) && !clr;
        drop       = wr_req && !bypass && (fifo_count >= CW'(Depth)) && !clr;
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q | drop;
        if (clr) begin
            state_d    = IDLE;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_d    = PRESENT;
                        out_data_d = fifo_head;
                    end else if (bypass) begin
                        state_d    = PRESENT;
                        out_data_d = RegIn;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (pop) begin
                            out_data_d = fifo_head;
                        end else if (bypass) begin
                            out_data_d = RegIn;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    out_port_fifo #(
        .Width (Psize),
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .nReset  (nReset),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .wr_data (RegIn),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (full)
    );

    assign out_data  = out_data_q;
    assign out_valid = (state_q == PRESENT);
    assign overflow  = overflow_q;
    assign count     = fifo_count;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: stimulus queues expected words, a negedge
// monitor compares each completed transfer in order.
module tb_out_port_ctrl;

    localparam int Psize = 8;
    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       nReset;
    logic       clr;
    logic       out_ready;
    logic [7:0] RegIn;
    logic [7:0] ALURes;
    logic [7:0] out_data;
    logic       out_valid;
    logic       full;
    logic       overflow;
    logic [2:0] count;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];

    out_port_ctrl #(
        .Psize      (Psize),
        .Depth      (Depth),
        .StrobeCode (8'hFF)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .RegIn     (RegIn),
        .ALURes    (ALURes),
        .clr       (clr),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (full),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; accepted writes are queued as expected output.
    task automatic step(input logic wr, input logic [7:0] d, input logic rdy, input bit accept);
        ALURes    = wr ? 8'hFF : 8'hFE;
        RegIn     = d;
        out_ready = rdy;
        if (wr && accept) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (nReset && !clr && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_xfer: got %0h expected none", out_data);
            end else begin
                logic [7:0] exp_v;
                exp_v = sb.pop_front();
                if (out_data !== exp_v) begin
                    failures++;
                    $display("[TB] FAIL xfer_data: got %0h expected %0h", out_data, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic wr_pat  [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
        logic rdy_pat [10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};

        nReset    = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        RegIn     = 8'h00;
        ALURes    = 8'h00;
        #8;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        #4 nReset = 1'b1;
        @(posedge clk);
        #1;

        // Single bypass write, one-cycle latency
        step(1, 8'h3C, 1, 1);
        check("byp_valid", 32'(out_valid), 1);
        check("byp_data", 32'(out_data), 32'h3C);
        check("byp_count", 32'(count), 0);
        step(0, 8'h00, 1, 0);
        check("byp_idle", 32'(out_valid), 0);
        check("byp_count2", 32'(count), 0);

        // Fill to capacity with a stalled consumer, then overflow
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 0, 1);
        step(1, 8'h44, 0, 1);
        step(1, 8'h55, 0, 1);
        check("fill_data", 32'(out_data), 32'h11);
        check("fill_count", 32'(count), 4);
        check("fill_full", 32'(full), 1);
        check("fill_ovf", 32'(overflow), 0);
        step(1, 8'h66, 0, 0);
        check("drop_ovf", 32'(overflow), 1);
        check("drop_count", 32'(count), 4);
        check("drop_hold", 32'(out_data), 32'h11);

        // Drain
        repeat (5) step(0, 8'h00, 1, 0);
        check("drain_valid", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
        check("drain_full", 32'(full), 0);
        check("drain_ovf", 32'(overflow), 1);

        // Simultaneous push/pop and mixed traffic across pointer wrap
        step(1, 8'hA1, 0, 1);
        step(1, 8'hA2, 0, 1);
        step(1, 8'hA3, 0, 1);
        check("pp_count_pre", 32'(count), 2);
        step(1, 8'hA4, 1, 1);
        check("pp_count", 32'(count), 2);
        for (int i = 0; i < 10; i++) begin
            step(wr_pat[i], 8'hB0 + 8'(i), rdy_pat[i], 1);
        end
        repeat (4) step(0, 8'h00, 1, 0);
        check("mix_valid", 32'(out_valid), 0);
        check("mix_count", 32'(count), 0);

        // clr outranks a simultaneous write and transfer
        step(1, 8'hC1, 0, 1);
        step(1, 8'hC2, 0, 1);
        step(1, 8'hC3, 0, 1);
        step(1, 8'hC4, 0, 1);
        check("clr_count_pre", 32'(count), 3);
        clr = 1'b1;
        sb.delete();
        step(1, 8'hC5, 1, 0);
        clr = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_valid", 32'(out_valid), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_full", 32'(full), 0);
        repeat (3) step(0, 8'h00, 1, 0);
        check("clr_after", 32'(out_valid), 0);

        // Asynchronous reset mid-cycle while presenting with queued data
        step(1, 8'hD1, 0, 1);
        step(1, 8'hD2, 0, 1);
        step(1, 8'hD3, 0, 1);
        check("ar_count_pre", 32'(count), 2);
        check("ar_valid_pre", 32'(out_valid), 1);
        ALURes = 8'hFE;
        #3 nReset = 1'b0;
        sb.delete();
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_data", 32'(out_data), 0);
        check("ar_count", 32'(count), 0);
        check("ar_full", 32'(full), 0);
        #3 nReset = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'hA5, 1, 1);
        check("ar_post_valid", 32'(out_valid), 1);
        check("ar_post_data", 32'(out_data), 32'hA5);
        check("ar_post_count", 32'(count), 0);
        step(0, 8'h00, 1, 0);
        check("ar_post_idle", 32'(out_valid), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/out_port_ctrl.md
OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
REQ-001 The block SHALL have parameter Psize, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter Depth, default 4, giving the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter StrobeCode, default 8'hFF, giving the ALU result value that requests an output write.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 nReset  input  1  reset; asynchronous, active-low.
REQ-006 RegIn  input  Psize  register-file data offered for output.
REQ-007 ALURes  input  Psize  ALU result; a value equal to StrobeCode marks a write request.
REQ-008 clr  input  1  synchronous flush.
REQ-009 out_ready  input  1  downstream consumer accepts out_data.
REQ-010 out_data  output  Psize  data presented downstream.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 full  output  1  the FIFO holds Depth entries; the processor uses this as a stall.
REQ-013 overflow  output  1  sticky flag: at least one write was dropped.
REQ-014 count  output  $clog2(Depth)+1  number of FIFO entries, excluding the output stage.

Function
REQ-015 A write request (wr_req) SHALL occur in every cycle where ALURes == StrobeCode, one write per cycle.
REQ-016 A write SHALL be accepted iff count < Depth at that edge, or the output stage takes it directly under REQ-018; otherwise it SHALL be dropped and overflow set.
REQ-017 The output stage SHALL have two states, IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-018 From IDLE, with the FIFO empty and wr_req true, the output stage SHALL load RegIn and enter PRESENT on the same edge (bypass), so latency is 1 cycle.
REQ-019 From IDLE, with the FIFO non-empty, the output stage SHALL load the FIFO head and enter PRESENT.
REQ-020 In PRESENT with out_ready=0, out_data and out_valid SHALL hold stable.
REQ-021 In PRESENT with out_ready=1, a transfer SHALL complete and the stage SHALL reload in the same edge:
  - from the FIFO head if the FIFO is non-empty;
  - else from the bypass if wr_req is true;
  - else it SHALL return to IDLE.
REQ-022 A simultaneous FIFO push and pop SHALL leave count unchanged, and data order SHALL be strictly FIFO (first written, first presented).
REQ-023 A write SHALL enter the FIFO (not the bypass) whenever the FIFO is non-empty or the output stage is PRESENT and not being reloaded by bypass.
REQ-024 Pointers SHALL wrap modulo Depth with no loss or duplication of data.
REQ-025 full SHALL equal (count == Depth), registered, with no combinational path from ALURes.
REQ-026 The total storage capacity SHALL be Depth+1 words, i.e. the FIFO plus the output stage.
REQ-027 clr=1 SHALL empty the FIFO, set out_valid=0 and clear overflow at the next edge; clr SHALL take priority over a simultaneous write or transfer, and that write SHALL be discarded without setting overflow.
REQ-028 overflow SHALL clear only on reset or clr.

Reset
REQ-029 While nReset=0, the block SHALL force out_valid=0, out_data=0, count=0, full=0, overflow=0, pointers=0, and the state to IDLE, immediately and independent of clk.
REQ-030 An assertion of reset mid-transfer SHALL discard all stored data, and the first edge after release SHALL behave as from IDLE with an empty FIFO.

Structure
REQ-031 A package out_port_pkg SHALL hold StrobeCode default, the default Depth, and an enum for the output-stage states {IDLE, PRESENT}.
REQ-032 The FIFO storage, pointers and count SHALL be one sub-module, out_port_fifo; out_port_ctrl SHALL hold the bypass and output-stage logic.

Verification
REQ-033 Reset then ALURes=FF, RegIn=8'h3C for 1 cycle with out_ready=1 -> out_valid=1 and out_data=3C the next cycle; IDLE the cycle after; count stays 0.
REQ-034 out_ready=0 and writes 11,22,33,44,55 on consecutive cycles -> 11 held in the output stage, count=4, full=1; then a 6th write of 66 -> dropped and overflow=1.
REQ-035 Continuing REQ-034, set out_ready=1 -> out_data sequence 11,22,33,44,55 on consecutive cycles, then out_valid=0 and count=0; overflow remains 1.
REQ-036 count=2, out_ready=1 and a write in the same cycle -> count stays 2; order is preserved across a pointer wrap over 10 mixed push/pop cycles.
REQ-037 Apply clr together with wr_req while count=3 -> next cycle count=0, out_valid=0, overflow=0, and the written value never appears at out_data.
REQ-038 nReset pulsed low mid-cycle while PRESENT with count=2 -> outputs zero immediately; after release a single write of 8'hA5 appears at out_data 1 cycle later.
